// File: rtl/egress_desc_queue_pkg.sv
// Shared constants and types for the per-output-port egress descriptor queue.
// Descriptor layout is {length, ptr}, matching the pre-arbiter output.
package egress_desc_queue_pkg;

  localparam int pPORT_NUM   = 4;
  localparam int lpLEN_W     = 6;
  localparam int lpPTR_W     = 10;
  localparam int pFIFO_WIDTH = lpLEN_W + lpPTR_W;
  localparam int pDEPTH      = 8;

  localparam int lpRR_W  = $clog2(pPORT_NUM);
  localparam int lpCNT_W = $clog2(pDEPTH) + 1;

  typedef enum logic {
    lpARB  = 1'b0,
    lpCAPT = 1'b1
  } state_e;

endpackage

// File: rtl/egress_desc_queue_desc_fifo.sv
// Synchronous first-word-fall-through descriptor FIFO with a separate occupancy counter.
// The head is shown combinationally from storage and reads as zero while empty.
module egress_desc_queue_desc_fifo #(
  parameter int pWIDTH = 16,
  parameter int pDEPTH = 8
) (
  input  logic                       iclk,
  input  logic                       irst,
  input  logic                       i_push,
  input  logic [pWIDTH-1:0]          i_data,
  input  logic                       i_pop,
  output logic [pWIDTH-1:0]          o_data,
  output logic [$clog2(pDEPTH):0]    o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int lpAW = $clog2(pDEPTH);

  logic [pWIDTH-1:0] r_mem [pDEPTH];
  logic [lpAW-1:0]   r_wptr;
  logic [lpAW-1:0]   r_rptr;
  logic [lpAW:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == (lpAW + 1)'(pDEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_count   = r_count;
  assign o_data    = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/egress_desc_queue.sv
// Round-robin arbiter collecting descriptors from the ingress pre-arbiters into an
// egress FIFO; one descriptor is granted and captured every two cycles at most.
module egress_desc_queue
  import egress_desc_queue_pkg::*;
(
  input  logic                             iclk,
  input  logic                             irst,
  input  logic [pPORT_NUM-1:0]             i_req,
  input  logic [pPORT_NUM*pFIFO_WIDTH-1:0] i_desc,
  output logic [pPORT_NUM-1:0]             o_grant,
  output logic                             o_tx_valid,
  output logic [pFIFO_WIDTH-1:0]           o_tx_desc,
  input  logic                             i_tx_ready,
  output logic [lpCNT_W-1:0]               o_count,
  output logic                             o_full,
  output logic                             o_empty
);

  state_e                 r_state;
  logic [lpRR_W-1:0]      r_rr;
  logic [lpRR_W-1:0]      r_sel;
  logic [pPORT_NUM-1:0]   r_grant;
  logic [lpRR_W-1:0]      w_pick;
  logic [lpRR_W-1:0]      w_idx;
  logic                   w_found;
  logic [pPORT_NUM-1:0]   w_onehot;
  logic [pFIFO_WIDTH-1:0] w_cap_desc;
  logic                   w_push;
  logic                   w_full;
  logic                   w_empty;

  // Scan rr+1, rr+2, ... so the most recently served port has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 1; i <= pPORT_NUM; i++) begin
      w_idx = lpRR_W'((int'(r_rr) + i) % pPORT_NUM);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_onehot = {{(pPORT_NUM-1){1'b0}}, 1'b1} << w_pick;

  always_comb begin
    w_cap_desc = '0;
    for (int k = 0; k < pPORT_NUM; k++) begin
      if (r_sel == lpRR_W'(k)) begin
        w_cap_desc = i_desc[k*pFIFO_WIDTH +: pFIFO_WIDTH];
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state <= lpARB;
      r_rr    <= lpRR_W'(pPORT_NUM - 1);
      r_sel   <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        lpARB: begin
          if (w_found && !w_full) begin
            r_grant <= w_onehot;
            r_sel   <= w_pick;
            r_state <= lpCAPT;
          end else begin
            r_grant <= '0;
          end
        end
        lpCAPT: begin
          r_rr    <= r_sel;
          r_grant <= '0;
          r_state <= lpARB;
        end
        default: r_state <= lpARB;
      endcase
    end
  end

  // Only one capture is ever in flight, so the full check at grant time covers the push.
  assign w_push = (r_state == lpCAPT);

  egress_desc_queue_desc_fifo #(
    .pWIDTH (pFIFO_WIDTH),
    .pDEPTH (pDEPTH)
  ) u_desc_fifo (
    .iclk    (iclk),
    .irst    (irst),
    .i_push  (w_push),
    .i_data  (w_cap_desc),
    .i_pop   (i_tx_ready),
    .o_data  (o_tx_desc),
    .o_count (o_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_grant    = r_grant;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_tx_valid = !w_empty;

endmodule

// File: tb/tb_egress_desc_queue.sv
// Bench for egress_desc_queue: directed vector table, hand-written corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_egress_desc_queue;
  import egress_desc_queue_pkg::*;

  localparam int N = pPORT_NUM;
  localparam int W = pFIFO_WIDTH;

  logic               clk   = 1'b0;
  logic               rst   = 1'b1;
  logic [N-1:0]       req   = '0;
  logic [N*W-1:0]     desc  = '0;
  logic               ready = 1'b0;
  logic [N-1:0]       grant;
  logic               valid;
  logic [W-1:0]       txd;
  logic [lpCNT_W-1:0] count;
  logic               full;
  logic               empty;

  always #5 clk = ~clk;

  egress_desc_queue u_dut (
    .iclk       (clk),
    .irst       (rst),
    .i_req      (req),
    .i_desc     (desc),
    .o_grant    (grant),
    .o_tx_valid (valid),
    .o_tx_desc  (txd),
    .i_tx_ready (ready),
    .o_count    (count),
    .o_full     (full),
    .o_empty    (empty)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: descriptor queue, last-served port, outstanding grant.
  logic [W-1:0] mq[$];
  int           m_last = N - 1;
  int           m_pend = -1;
  logic [N-1:0] m_grant = '0;
  logic [N-1:0] drop_pend = '0;
  bit           auto_raise = 1'b0;
  int           raise_pct = 0;

  task automatic cycle();
    logic [N-1:0] req_s;
    bit           rdy_s;
    bit           rst_s;
    int           pick;
    int           sz;
    logic [W-1:0] head;
    req_s = req;
    rdy_s = ready;
    rst_s = rst;
    pick  = -1;
    sz    = mq.size();
    if (rst_s) begin
      mq.delete();
      m_last    = N - 1;
      m_pend    = -1;
      m_grant   = '0;
      drop_pend = '0;
    end else begin
      m_grant = '0;
      if (m_pend < 0 && sz < pDEPTH) begin
        for (int i = 1; i <= N; i++) begin
          if (pick < 0 && req_s[(m_last + i) % N]) pick = (m_last + i) % N;
        end
      end
      if (rdy_s && sz > 0) void'(mq.pop_front());
      if (m_pend >= 0) begin
        mq.push_back(desc[m_pend*W +: W]);
        m_last = m_pend;
        m_pend = -1;
      end else if (pick >= 0) begin
        m_pend        = pick;
        m_grant[pick] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    head = (mq.size() > 0) ? mq[0] : '0;
    check("grant", 32'(grant), 32'(m_grant));
    check("count", 32'(count), 32'(mq.size()));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() == pDEPTH));
    check("valid", 32'(valid), 32'(mq.size() > 0));
    check("head", 32'(txd), 32'(head));
    if (!rst_s) begin
      for (int p = 0; p < N; p++) begin
        if (drop_pend[p]) begin
          req[p]       = 1'b0;
          drop_pend[p] = 1'b0;
        end else if (grant[p]) begin
          drop_pend[p] = 1'b1;
        end
      end
      if (auto_raise) begin
        for (int p = 0; p < N; p++) begin
          if (!req[p] && !drop_pend[p] && $urandom_range(99) < raise_pct) begin
            req[p]          = 1'b1;
            desc[p*W +: W] = W'($urandom);
          end
        end
      end
    end
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    req        = '0;
    ready      = 1'b0;
    auto_raise = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         rdy;
    logic [N*W-1:0] d;
    logic [N-1:0] eg;
    logic         ev;
    logic [W-1:0] ed;
    int           ec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [N-1:0] rq, input logic rd, input logic [N*W-1:0] d,
                     input logic [N-1:0] eg, input logic ev, input logic [W-1:0] ed, input int ec);
    vec_t v;
    v.rst = r; v.req = rq; v.rdy = rd; v.d = d; v.eg = eg; v.ev = ev; v.ed = ed; v.ec = ec;
    tbl.push_back(v);
  endtask

  initial begin
    logic [N*W-1:0] d2;
    logic [N*W-1:0] d3;
    d2 = '0;
    d2[2*W +: W] = W'(16'h00A5);
    for (int p = 0; p < N; p++) d3[p*W +: W] = W'(16'h0010 + p);

    // Single request from port 2: grant one cycle, entry visible at the capture edge.
    add(1, 4'h0, 0, d2, 4'h0, 0, 16'h0000, 0);
    add(0, 4'h4, 0, d2, 4'h4, 0, 16'h0000, 0);
    add(0, 4'h4, 0, d2, 4'h0, 1, 16'h00A5, 1);
    add(0, 4'h0, 0, d2, 4'h0, 1, 16'h00A5, 1);
    // Reset held with all requesting, then round-robin service 0,1,2,3 and drain in order.
    add(1, 4'hF, 0, d3, 4'h0, 0, 16'h0000, 0);
    add(1, 4'hF, 0, d3, 4'h0, 0, 16'h0000, 0);
    add(1, 4'hF, 0, d3, 4'h0, 0, 16'h0000, 0);
    add(0, 4'hF, 0, d3, 4'h1, 0, 16'h0000, 0);
    add(0, 4'hF, 0, d3, 4'h0, 1, 16'h0010, 1);
    add(0, 4'hE, 0, d3, 4'h2, 1, 16'h0010, 1);
    add(0, 4'hE, 0, d3, 4'h0, 1, 16'h0010, 2);
    add(0, 4'hC, 0, d3, 4'h4, 1, 16'h0010, 2);
    add(0, 4'hC, 0, d3, 4'h0, 1, 16'h0010, 3);
    add(0, 4'h8, 0, d3, 4'h8, 1, 16'h0010, 3);
    add(0, 4'h8, 0, d3, 4'h0, 1, 16'h0010, 4);
    add(0, 4'h0, 1, d3, 4'h0, 1, 16'h0011, 3);
    add(0, 4'h0, 1, d3, 4'h0, 1, 16'h0012, 2);
    add(0, 4'h0, 1, d3, 4'h0, 1, 16'h0013, 1);
    add(0, 4'h0, 1, d3, 4'h0, 0, 16'h0000, 0);
    add(0, 4'h0, 1, d3, 4'h0, 0, 16'h0000, 0);

    foreach (tbl[i]) begin
      rst   = tbl[i].rst;
      req   = tbl[i].req;
      ready = tbl[i].rdy;
      desc  = tbl[i].d;
      @(posedge clk);
      #1;
      check($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].eg));
      check($sformatf("row%0d valid", i), 32'(valid), 32'(tbl[i].ev));
      check($sformatf("row%0d head", i), 32'(txd), 32'(tbl[i].ed));
      check($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].ec));
      check($sformatf("row%0d full", i), 32'(full), 32'(tbl[i].ec == pDEPTH));
      check($sformatf("row%0d empty", i), 32'(empty), 32'(tbl[i].ec == 0));
    end

    // Fill to full with continuous requests, then one pop re-opens arbitration.
    reset_dut();
    auto_raise = 1'b1;
    raise_pct  = 100;
    req        = '1;
    for (int c = 0; c < 24; c++) cycle();
    check("t4 count", 32'(count), 32'(pDEPTH));
    check("t4 full", 32'(full), 32'd1);
    check("t4 nogrant", 32'(grant), 32'd0);
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    check("t4 count after pop", 32'(count), 32'(pDEPTH - 1));
    cycle();
    check("t4 regrant", 32'(grant != '0), 32'd1);
    cycle();

    // Push and pop on the same edge at occupancy 3.
    reset_dut();
    desc[0*W +: W] = W'(16'h1111);
    desc[1*W +: W] = W'(16'h2222);
    desc[2*W +: W] = W'(16'h3333);
    req = 4'b0111;
    for (int c = 0; c < 6; c++) cycle();
    check("t5 count3", 32'(count), 32'd3);
    req[3] = 1'b1;
    desc[3*W +: W] = W'(16'h4444);
    cycle();
    check("t5 grant3", 32'(grant), 32'b1000);
    ready = 1'b1;
    check("t5 popped oldest", 32'(txd), 32'h1111);
    cycle();
    ready = 1'b0;
    check("t5 count held", 32'(count), 32'd3);
    check("t5 new head", 32'(txd), 32'h2222);

    // Reset while a capture is pending: nothing written, round-robin restarts at port 0.
    reset_dut();
    desc[2*W +: W] = W'(16'h5A5A);
    req = 4'b0100;
    cycle();
    check("t6 grant2", 32'(grant), 32'b0100);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6 empty", 32'(empty), 32'd1);
    req = 4'hF;
    cycle();
    check("t6 port0 first", 32'(grant), 32'b0001);

    // Randomized traffic with varying back-pressure.
    reset_dut();
    auto_raise = 1'b1;
    raise_pct  = 35;
    for (int c = 0; c < 600; c++) begin
      ready = ($urandom_range(99) < ((c < 300) ? 20 : 70));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
